// File: rtl/fp_acc_pkg.sv
// Shared types and constants for the FP accumulator slice.
package fp_acc_pkg;
  localparam int MAX_LEN = 256;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
  localparam logic [7:0]  FP_EXP_ONES = 8'hFF;
endpackage

// File: rtl/fp_accumulator_if.sv
// Control, streaming-input and result bundle of the accumulator.
// master = requester side, slave = accumulator side.
interface fp_accumulator_if;
  import fp_acc_pkg::*;

  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      acc_out;
  logic             busy;
  logic             overflow;
  logic             special_seen;

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, acc_out, busy, overflow, special_seen
  );

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, acc_out, busy, overflow, special_seen
  );
endinterface

// File: rtl/floating_point_adder.sv
// Combinational IEEE-754 single adder: truncating, subnormals flushed to zero.
// Zero latency; no flow control. overflow flags a finite sum rounding out to Inf.
module floating_point_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        overflow,
  output logic        cout
);
  logic [31:0] big, sml;
  logic [23:0] mb, ms;
  logic [7:0]  diff;
  logic [26:0] ms_al;
  logic [27:0] s, norm;
  logic [4:0]  lead, sh;
  logic [9:0]  exp_r;
  logic        a_nan, b_nan, a_ones, b_ones;

  always_comb begin
    sum      = 32'h0;
    overflow = 1'b0;
    lead     = 5'd0;
    norm     = '0;
    exp_r    = '0;
    // Magnitude ordering of IEEE values matches unsigned ordering of bits 30:0.
    if (a[30:0] >= b[30:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    mb    = (big[30:23] == 8'h00) ? 24'h0 : {1'b1, big[22:0]};
    ms    = (sml[30:23] == 8'h00) ? 24'h0 : {1'b1, sml[22:0]};
    diff  = big[30:23] - sml[30:23];
    ms_al = (diff > 8'd26) ? 27'h0 : ({ms, 3'b000} >> diff);
    if (big[31] == sml[31]) s = {1'b0, mb, 3'b000} + {1'b0, ms_al};
    else                    s = {1'b0, mb, 3'b000} - {1'b0, ms_al};
    cout = s[27];
    for (int i = 0; i < 27; i++) begin
      if (s[i]) lead = 5'(i);
    end
    sh = 5'd26 - lead;

    a_ones = (a[30:23] == 8'hFF);
    b_ones = (b[30:23] == 8'hFF);
    a_nan  = a_ones && (a[22:0] != 23'h0);
    b_nan  = b_ones && (b[22:0] != 23'h0);

    if (a_ones || b_ones) begin
      if (a_nan || b_nan || (a_ones && b_ones && (a[31] != b[31])))
        sum = 32'h7FC0_0000;
      else
        sum = {big[31], 8'hFF, 23'h0};
    end else if (s[27]) begin
      exp_r = {2'b00, big[30:23]} + 10'd1;
      if (exp_r >= 10'd255) begin
        sum      = {big[31], 8'hFF, 23'h0};
        overflow = 1'b1;
      end else begin
        sum = {big[31], exp_r[7:0], s[26:4]};
      end
    end else if (s != 28'h0) begin
      norm = s << sh;
      if ({2'b00, big[30:23]} > {5'b00000, sh}) begin
        exp_r = {2'b00, big[30:23]} - {5'b00000, sh};
        sum   = {big[31], exp_r[7:0], norm[25:3]};
      end
    end
  end
endmodule

// File: rtl/fp_accumulator.sv
// Burst FP accumulator around floating_point_adder; one element/cycle, result held until out_ready.
// Optional FP_ACC_SPECIAL_EN: flags Inf/NaN inputs and pins the total to quiet NaN after a NaN.
module fp_accumulator
  import fp_acc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  fp_accumulator_if.slave   bus
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] len_sat;
  logic [31:0]      acc_q, acc_nxt, add_sum;
  logic             ovf_q, add_ovf, add_cout_unused;
  logic             in_rdy, beat;

  assign len_sat = (bus.len > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : bus.len;
  assign beat    = bus.in_valid && in_rdy;

  floating_point_adder u_add (
    .a        (acc_q),
    .b        (bus.in_data),
    .sum      (add_sum),
    .overflow (add_ovf),
    .cout     (add_cout_unused)
  );

  always_comb begin
    state_d       = state_q;
    in_rdy        = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = (len_sat == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        in_rdy   = 1'b1;
        bus.busy = 1'b1;
        if (beat && (count == CNT_W'(1))) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

`ifdef FP_ACC_SPECIAL_EN
  logic in_special, in_nan, nan_q, spc_q;

  assign in_special = (bus.in_data[30:23] == FP_EXP_ONES);
  assign in_nan     = in_special && (bus.in_data[22:0] != 23'h0);
  // Once a NaN has entered the burst the total stays canonical qNaN.
  assign acc_nxt    = (nan_q || in_nan) ? FP_QNAN : add_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nan_q <= 1'b0;
      spc_q <= 1'b0;
    end else if (state_q == IDLE && bus.start) begin
      nan_q <= 1'b0;
      spc_q <= 1'b0;
    end else if (beat) begin
      nan_q <= nan_q | in_nan;
      spc_q <= spc_q | in_special;
    end
  end

  assign bus.special_seen = spc_q;
`else
  assign acc_nxt          = add_sum;
  assign bus.special_seen = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      acc_q <= FP_POS_ZERO;
      ovf_q <= 1'b0;
    end else if (state_q == IDLE && bus.start) begin
      count <= len_sat;
      acc_q <= FP_POS_ZERO;
      ovf_q <= 1'b0;
    end else if (beat) begin
      count <= count - CNT_W'(1);
      acc_q <= acc_nxt;
      ovf_q <= ovf_q | add_ovf;
    end
  end

  assign bus.in_ready = in_rdy;
  assign bus.acc_out  = acc_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_fp_accumulator.sv
// Table-driven bench for fp_accumulator with a result scoreboard plus hand-written corner sequences.
module tb_fp_accumulator;
  import fp_acc_pkg::*;

  typedef struct {
    logic [CNT_W-1:0]  len;
    int                gap;
    logic [3:0][31:0]  d;
    logic [31:0]       acc;
    logic              ovf;
    logic              spc;
  } vec_t;

  typedef struct {
    logic [31:0] acc;
    logic        ovf;
    logic        spc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vt[$];

  fp_accumulator_if bus ();

  fp_accumulator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int len, input int gap,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input logic [31:0] acc, input logic ovf, input logic spc);
    vec_t v;
    v.len = CNT_W'(len);
    v.gap = gap;
    v.d   = {d3, d2, d1, d0};
    v.acc = acc;
    v.ovf = ovf;
    v.spc = spc;
    return v;
  endfunction

  // Result monitor: every out_valid/out_ready handshake retires one expected record.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_acc", bus.acc_out, e.acc);
        chk("res_ovf", {31'b0, bus.overflow}, {31'b0, e.ovf});
        chk("res_spc", {31'b0, bus.special_seen}, {31'b0, e.spc});
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle.
  task automatic run_vec(input vec_t v);
    int nb;
    nb = (int'(v.len) > MAX_LEN) ? MAX_LEN : int'(v.len);
    bus.start = 1'b1;
    bus.len   = v.len;
    sb.push_back('{v.acc, v.ovf, v.spc});
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (i > 0) begin
        repeat (v.gap) begin
          bus.in_valid = 1'b0;
          @(negedge clk);
          chk("gap_in_ready", {31'b0, bus.in_ready}, 32'd1);
          @(posedge clk); #1;
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = (i < 4) ? v.d[i] : v.d[0];
      @(negedge clk);
      chk("beat_in_ready", {31'b0, bus.in_ready}, 32'd1);
      if (i == nb - 1) chk("early_out_valid", {31'b0, bus.out_valid}, 32'd0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    chk("done_out_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("done_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("done_busy", {31'b0, bus.busy}, 32'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("idle_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("idle_busy", {31'b0, bus.busy}, 32'd0);
    chk("idle_acc_kept", bus.acc_out, v.acc);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (errors so far %0d)", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus.out_ready = 1'b0;

    vt.push_back(mk(3, 0, 32'h3F800000, 32'h40000000, 32'h40800000, 32'h0, 32'h40E00000, 1'b0, 1'b0));
    vt.push_back(mk(2, 3, 32'h3F800000, 32'hBF800000, 32'h0, 32'h0, 32'h00000000, 1'b0, 1'b0));
    vt.push_back(mk(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000000, 1'b0, 1'b0));
    vt.push_back(mk(2, 0, 32'h7F000000, 32'h7F000000, 32'h0, 32'h0, 32'h7F800000, 1'b1, 1'b0));
    vt.push_back(mk(4, 1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40800000, 1'b0, 1'b0));
    vt.push_back(mk(2, 0, 32'h40400000, 32'hC0000000, 32'h0, 32'h0, 32'h3F800000, 1'b0, 1'b0));
`ifdef FP_ACC_SPECIAL_EN
    vt.push_back(mk(2, 0, 32'h7FC00000, 32'h3F800000, 32'h0, 32'h0, 32'h7FC00000, 1'b0, 1'b1));
    vt.push_back(mk(2, 0, 32'h7F800000, 32'h7F800000, 32'h0, 32'h0, 32'h7F800000, 1'b0, 1'b1));
`endif
    vt.push_back(mk(2, 2, 32'h3F000000, 32'h3E800000, 32'h0, 32'h0, 32'h3F400000, 1'b0, 1'b0));
    // Oversized length saturates to MAX_LEN beats of 1.0 -> 256.0.
    vt.push_back(mk(300, 0, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h43800000, 1'b0, 1'b0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_acc", bus.acc_out, 32'h0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_ovf", {31'b0, bus.overflow}, 32'd0);
    chk("rst_spc", {31'b0, bus.special_seen}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vt[k]) run_vec(vt[k]);

    // Held result in DONE: out_ready low for 5 cycles while start pulses.
    bus.start = 1'b1;
    bus.len   = CNT_W'(1);
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h3F800000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.start = (c % 2 == 0);
      bus.len   = CNT_W'(3);
      @(negedge clk);
      chk("hold_out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("hold_acc", bus.acc_out, 32'h3F800000);
      @(posedge clk); #1;
    end
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    sb.push_back('{32'h3F800000, 1'b0, 1'b0});
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("hs_start_ignored_busy", {31'b0, bus.busy}, 32'd0);
    chk("hs_out_valid", {31'b0, bus.out_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("still_idle_busy", {31'b0, bus.busy}, 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset after the first of three beats.
    bus.start = 1'b1;
    bus.len   = CNT_W'(3);
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h40400000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("pre_rst_acc", bus.acc_out, 32'h40400000);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_acc", bus.acc_out, 32'h0);
    chk("arst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("arst_busy", {31'b0, bus.busy}, 32'd0);
    chk("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(mk(1, 0, 32'h40000000, 32'h0, 32'h0, 32'h0, 32'h40000000, 1'b0, 1'b0));

    repeat (2) @(posedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_accumulator.md
# fp_accumulator

Sequential IEEE-754 single-precision accumulator that sums a burst of operands into a running total. Sits directly around the combinational `floating_point_adder`: it feeds the running total as operand A and each incoming stream element as operand B, then registers the adder's `sum` as the next total. Valid/ready streaming input, one-shot start/length control and a held result with handshake. Used wherever vector reductions (dot-product tails, sums) need the existing FP adder.

## Interface
- `MAX_LEN`, 256: maximum elements per burst.
- `CNT_W`, `$clog2(MAX_LEN+1)`: width of length/count fields.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a burst; sampled only in IDLE.
- `len`  in  CNT_W  element count for the burst, sampled with `start`; values > MAX_LEN saturate to MAX_LEN.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  accumulator accepts an element.
- `in_data`  in  32  IEEE-754 operand.
- `out_valid`  out  1  `acc_out` holds the final sum.
- `out_ready`  in  1  consumer takes the result.
- `acc_out`  out  32  running/final total (registered).
- `busy`  out  1  high in ACCUM or DONE.
- `overflow`  out  1  sticky OR of adder `overflow` over the burst.
- `special_seen`  out  1  sticky Inf/NaN-input flag (see Configuration).

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE: `in_ready`=0, `out_valid`=0. On `start`: `acc_out`←32'h00000000, `overflow`←0, `special_seen`←0, `count`←len; next state is ACCUM if len≠0, else DONE.
- ACCUM: `in_ready`=1. A beat is accepted when `in_valid && in_ready`. On each accepted beat: `acc_out`←adder.sum(A=`acc_out`, B=`in_data`), `overflow` |= adder.overflow, `count` decrements. The beat that takes `count` from 1 to 0 moves the FSM to DONE. `in_valid` gaps stall the FSM with no state change. Adder `cout` is ignored.
- DONE: `out_valid`=1 and `acc_out` is held. On `out_ready`: FSM returns to IDLE and `acc_out` keeps its value.
- `start` is ignored outside IDLE, including in the cycle DONE→IDLE.
- Reset mid-operation aborts the burst and discards the partial sum.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `busy`=0, `overflow`=0, `special_seen`=0, `acc_out`=32'h0, FSM in IDLE, `count`=0.
- `start` at edge N: `in_ready` is high from cycle N+1.
- Throughput is one element per cycle. The adder is combinational, and its result is registered at the edge that accepts the beat.
- `out_valid` rises the cycle after the last accepted beat. For len=0 it rises the cycle after `start`.
- The earliest next `start` is accepted the cycle after the `out_valid && out_ready` handshake.

## Configuration
- `FP_ACC_SPECIAL_EN` defined:
  - An input with exponent 8'hFF sets `special_seen`.
  - A NaN input (mantissa ≠ 0) forces `acc_out`←32'h7FC00000. The total is held at that value for the rest of the burst; remaining beats are still consumed and `count` still decrements.
- `FP_ACC_SPECIAL_EN` undefined:
  - No detection logic is built.
  - `special_seen` is tied to 0.
  - Operands pass raw to the adder.

## Structure
- Package `fp_acc_pkg` holds:
  - state typedef: IDLE=2'b00, ACCUM=2'b01, DONE=2'b10;
  - constants `FP_POS_ZERO`=32'h00000000, `FP_QNAN`=32'h7FC00000, `FP_EXP_ONES`=8'hFF.
- One sub-module: the existing `floating_point_adder`, instantiated once, with A=`acc_out` and B=`in_data`.

## Test plan
- len=3; back-to-back 3F800000, 40000000, 40800000 -> `out_valid` the cycle after beat 3, `acc_out`=40E00000, `overflow`=0.
- len=2; 3F800000 then BF800000 with 3 idle `in_valid` cycles between -> `acc_out`=00000000, `in_ready` stays high through the gap, `out_valid` the cycle after beat 2.
- len=0 -> `out_valid` the cycle after `start`, `acc_out`=00000000, `in_ready` never high.
- Hold `out_ready`=0 for 5 cycles in DONE and pulse `start` -> `acc_out` and `out_valid` stable, `start` ignored; `out_ready`=1 -> IDLE next cycle.
- len=3, drop `rst_n` after beat 1 -> all outputs return to reset values immediately without a clock edge; after release, a new len=1 burst of 40000000 gives 40000000.
- With `FP_ACC_SPECIAL_EN`: len=2 of 7FC00000, 3F800000 -> `acc_out`=7FC00000, `special_seen`=1. len=2 of 7F800000, 7F800000 -> `overflow` follows the adder's flag and `special_seen`=1.
